// File: rtl/inst_fetch.sv
// inst_fetch: PC owner, ROM driver and decoder-side instruction buffer.
// Define FETCH_SKID_EN for a 2-entry skid buffer (1 inst/cycle).
module inst_fetch #(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              jump_en,
    input  logic [4:0]        jump_addr,
    input  logic              branch_en,
    input  logic [2:0]        branch_off,
    input  logic [PC_W-1:0]   branch_pc,
    input  logic              halt_req,
    output logic              halted
);

`ifdef FETCH_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [0:0] LAST = 1'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_HALTED
    } state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } entry_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] inflight_pc;
    logic [PC_W-1:0] target;
    logic            inflight;
    logic            redirect;
    logic            pop;
    logic            push;
    logic [1:0]      occ;
    logic [2:0]      fill;
    logic [0:0]      wr_ptr;
    logic [0:0]      rd_ptr;
    entry_t          mem [DEPTH];

    function automatic logic [0:0] nxt(input logic [0:0] p);
        return (p == LAST) ? 1'b0 : p + 1'b1;
    endfunction

    assign redirect   = jump_en | branch_en;
    assign pop        = inst_valid & inst_ready;
    assign push       = inflight & ~redirect;
    assign inst_valid = (occ != 2'd0);
    assign inst       = mem[rd_ptr].inst;
    assign inst_pc    = mem[rd_ptr].pc;
    assign imem_addr  = pc;

    // Slots committed next cycle: buffered plus in-flight, less the pop.
    assign fill = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    assign imem_en = (state == S_RUN) & ~redirect & ~halt_req
                   & (fill < 3'(DEPTH));

    always_comb begin
        target = pc;
        if (jump_en) begin
            target = {{(PC_W-5){1'b0}}, jump_addr};
        end else if (branch_en) begin
            target = branch_pc + PC_W'(1)
                   + {{(PC_W-3){branch_off[2]}}, branch_off};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RESET;
            halted <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: begin
                    state  <= S_RUN;
                    halted <= 1'b0;
                end
                S_RUN: begin
                    if (halt_req & ~redirect) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (redirect) begin
                        state  <= S_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_RESET;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            occ         <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (redirect) begin
            // Drop buffered and returning data; restart at target.
            pc       <= target;
            inflight <= 1'b0;
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                pc          <= pc + PC_W'(1);
                inflight_pc <= pc;
            end
            if (push) begin
                mem[wr_ptr] <= '{inst: imem_rdata, pc: inflight_pc};
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
